adc_channel_packer: RTL and testbench
=====================================

Name: adc_channel_packer

Overview:
- Single-clock, N-channel ADC sample aligner and packer. Sits after the per-channel clock-domain-crossing FIFOs, in the system clock domain.
- Buffers each channel's samples in a private FIFO.
- Emits one packed word holding one sample from every enabled channel, over a valid/ready handshake.
- Replaces fixed two-channel concatenation with width, depth, channel count and channel-enable control, plus overflow reporting.

Parameters:
- N_CH, 4, number of ADC channels (2..8)
- SAMPLE_W, 12, bits per sample
- DEPTH, 8, entries per channel FIFO; power of two, 4..64

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously
- ch_en_i  in  N_CH  channel enable mask; bit c enables channel c
- in_valid_i  in  N_CH  per-channel sample strobe
- in_data_i  in  N_CH*SAMPLE_W  channel c in bits [c*SAMPLE_W +: SAMPLE_W]
- out_valid_o  out  1  packed word valid
- out_ready_i  in  1  downstream accept
- out_data_o  out  N_CH*SAMPLE_W  packed word; channel 0 in the MSB slot, channel N_CH-1 in the LSB slot
- ovf_o  out  N_CH  sticky per-channel overflow flags
- ovf_clr_i  in  1  synchronous clear of ovf_o
- level_o  out  $clog2(DEPTH+1)  fill level of the fullest enabled channel FIFO

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, ovf_o=0, level_o=0, all FIFO pointers and counts = 0.
- Per-channel FIFO: write when in_valid_i[c] && ch_en_i[c] && (count<DEPTH || pop this cycle).
- Full FIFO without a same-cycle pop: the sample is dropped and ovf_o[c] is set. Contents are unchanged.
- Samples on a disabled channel are ignored and never set its ovf bit.
- Pointers wrap modulo DEPTH. count is kept separately so full and empty are unambiguous.
- Pop condition:
  - every enabled channel has count>0;
  - at least one channel is enabled;
  - the output register is empty or is being accepted this cycle (out_valid_o && out_ready_i).
- On pop:
  - all enabled FIFOs advance together;
  - the output register loads the heads;
  - disabled channel slots load zero;
  - out_valid_o=1 next cycle.
- Latency: a sample written at cycle k is at its FIFO head at k+1. With all channels aligned and output free, out_valid_o rises at k+2.
- Output hold: while out_valid_o && !out_ready_i, out_data_o and out_valid_o are stable. Full throughput is one word per cycle while out_ready_i=1.
- If out_ready_i=1 and no pop is possible, out_valid_o drops to 0 next cycle.
- ch_en_i change, detected against a registered copy:
  - all FIFOs are flushed (count=0) on the following cycle;
  - out_valid_o clears;
  - in_valid_i on that same flush cycle is discarded.
  - Guarantees re-alignment after a channel-set change.
- ovf_clr_i has priority over a same-cycle overflow set: the bit reads 0 next cycle, and a new overflow on the cycle after sets it again.
- level_o is registered and reflects counts after the current cycle's push/pop. It is 0 when no channel is enabled.
- Reset mid-transfer: everything returns to reset values immediately. Buffered samples are lost and no partial word is emitted after release.

Optional Feature:
- Macro ADC_PACKER_TIMESTAMP_EN.
- When defined:
  - adds output ts_o [31:0] and a 32-bit free-running cycle counter, reset to 0, wrapping at 2^32;
  - on each pop, ts_o loads the counter value of the pop cycle;
  - ts_o obeys the same hold rule as out_data_o.
- When undefined: ts_o and the counter do not exist and behaviour is otherwise identical.

Test Plan:
- Basic alignment: N_CH=4, ch_en=4'hF, each channel writes 0x100+c once on the same cycle, out_ready=1 -> one word 0x100_101_102_103 two cycles later, out_valid high for exactly 1 cycle.
- Skew: channel 0 writes 3 samples at cycles 0-2, channels 1-3 write at cycles 5-7, out_ready=1 -> first out_valid at cycle 7, three consecutive words, correct per-channel ordering, ovf_o=0.
- Overflow: DEPTH=8, out_ready=0, channel 2 writes 10 samples with channels 0,1,3 keeping pace -> 8 words retained, 9th/10th of channel 2 dropped, ovf_o=4'b0100. ovf_clr_i pulse -> ovf_o=0.
- Backpressure: continuous writes on all channels, out_ready toggling 1,0,0,1 -> out_data_o stable during stalls, no loss, no duplication, sequence monotonic.
- Mask change: ch_en 4'hF -> 4'h5 mid-stream -> all FIFOs flushed, out_valid clears. Subsequent words carry channels 0/2 data with channel 1/3 slots = 0. level_o tracks only channels 0 and 2.
- Reset: rst_n_i low for 1 cycle with 5 samples buffered and out_valid=1 -> all outputs 0 immediately, no word emitted until new aligned samples arrive. With ADC_PACKER_TIMESTAMP_EN, ts_o restarts from 0.

Source files
------------

// File: rtl/adc_channel_packer.sv
// N-channel ADC sample aligner/packer: per-channel FIFOs, one packed word per pop.
// Optional macro ADC_PACKER_TIMESTAMP_EN adds ts_o, the cycle count captured on each pop.
module adc_channel_packer #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [N_CH-1:0]            ch_en_i,
    input  logic [N_CH-1:0]            in_valid_i,
    input  logic [N_CH*SAMPLE_W-1:0]   in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N_CH*SAMPLE_W-1:0]   out_data_o,
    output logic [N_CH-1:0]            ovf_o,
    input  logic                       ovf_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef ADC_PACKER_TIMESTAMP_EN
    ,
    output logic [31:0]                ts_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [N_CH-1:0]          ch_en_q;
    logic [SAMPLE_W-1:0]      mem       [N_CH][DEPTH];
    logic [PTR_W-1:0]         wr_ptr    [N_CH];
    logic [PTR_W-1:0]         rd_ptr    [N_CH];
    logic [CNT_W-1:0]         count     [N_CH];
    logic [CNT_W-1:0]         count_nxt [N_CH];
    logic [CNT_W-1:0]         level_nxt;
    logic [N_CH-1:0]          push;
    logic [N_CH-1:0]          ovf_set;
    logic [N_CH-1:0]          has_data;
    logic                     flush;
    logic                     pop;
    logic [N_CH*SAMPLE_W-1:0] head_word;

    always_comb begin
        // Any change of the enable mask re-aligns all channels by discarding buffered data.
        flush     = (ch_en_i != ch_en_q);
        has_data  = '0;
        push      = '0;
        ovf_set   = '0;
        head_word = '0;
        level_nxt = '0;
        count_nxt = '{default: '0};
        for (int unsigned c = 0; c < N_CH; c++) begin
            has_data[c] = !ch_en_i[c] || (count[c] != '0);
        end
        pop = !flush && (|ch_en_i) && (&has_data) && (!out_valid_o || out_ready_i);
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (!flush && in_valid_i[c] && ch_en_i[c]) begin
                if (count[c] != FULL_CNT || pop) begin
                    push[c] = 1'b1;
                end else begin
                    ovf_set[c] = 1'b1;
                end
            end
            if (ch_en_i[c]) begin
                head_word[(N_CH-1-c)*SAMPLE_W +: SAMPLE_W] = mem[c][rd_ptr[c]];
            end
            if (flush) begin
                count_nxt[c] = '0;
            end else begin
                count_nxt[c] = count[c] + CNT_W'(push[c]) - CNT_W'(pop && ch_en_i[c]);
            end
            if (ch_en_i[c] && (count_nxt[c] > level_nxt)) begin
                level_nxt = count_nxt[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ch_en_q     <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            ovf_o       <= '0;
            level_o     <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            ch_en_q <= ch_en_i;
            level_o <= level_nxt;
            ovf_o   <= ovf_clr_i ? '0 : (ovf_o | ovf_set);
            for (int unsigned c = 0; c < N_CH; c++) begin
                count[c] <= count_nxt[c];
                if (flush) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                end else begin
                    if (push[c]) begin
                        wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                    end
                    if (pop && ch_en_i[c]) begin
                        rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                    end
                end
            end
            if (flush) begin
                out_valid_o <= 1'b0;
            end else if (pop) begin
                out_valid_o <= 1'b1;
                out_data_o  <= head_word;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= in_data_i[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

`ifdef ADC_PACKER_TIMESTAMP_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_cnt <= '0;
            ts_o    <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (pop) begin
                ts_o <= cyc_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_channel_packer.sv
// Scoreboard bench for adc_channel_packer (N_CH=4, SAMPLE_W=12, DEPTH=8).
`timescale 1ns/1ps
module tb_adc_channel_packer;
    localparam int unsigned N_CH     = 4;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned W        = N_CH*SAMPLE_W;
    localparam int unsigned LW       = $clog2(DEPTH+1);

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic [N_CH-1:0] ch_en     = 4'hF;
    logic [N_CH-1:0] in_valid  = '0;
    logic [W-1:0]    in_data   = '0;
    logic            out_ready = 1'b1;
    logic            ovf_clr   = 1'b0;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [N_CH-1:0] ovf;
    logic [LW-1:0]   level;
`ifdef ADC_PACKER_TIMESTAMP_EN
    logic [31:0]     ts;
`endif

    always #5 clk = ~clk;

    adc_channel_packer #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .ch_en_i    (ch_en),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr),
        .level_o    (level)
`ifdef ADC_PACKER_TIMESTAMP_EN
        ,
        .ts_o       (ts)
`endif
    );

    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    exp_w;
    int              checks = 0;
    int              errors = 0;
    logic            prev_stall = 1'b0;
    logic [W-1:0]    prev_data = '0;
    logic [N_CH-1:0] last_en = '0;

    // Packed word: channel 0 in the MSB slot.
    function automatic logic [W-1:0] word4(input logic [11:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    // Input bus: channel 0 in the LSB slot.
    function automatic logic [W-1:0] din4(input logic [11:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Scoreboard and hold monitor; stalls across a mask change are legitimately flushed.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no word", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL word: got %h, required %h", out_data, exp_w);
                    end
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (ch_en == last_en);
            prev_data  = out_data;
        end
        last_en = ch_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", out_data); end
        if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d, required 0", level); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %0b, required 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        w = word4(12'h100, 12'h101, 12'h102, 12'h103);
        out_ready = 1'b1;
        exp_q.push_back(w);
        in_valid = 4'hF;
        in_data  = din4(12'h100, 12'h101, 12'h102, 12'h103);
        tick();
        in_valid = '0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %0b, required 0", out_valid); end
        if (level !== LW'(1)) begin errors++; $display("FAIL basic_level: got %0d, required 1", level); end
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b, required 1", out_valid); end
        if (out_data !== w) begin errors++; $display("FAIL basic_data: got %h, required %h", out_data, w); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0b, required 0", out_valid); end
        wait_drain(10, "basic");
    endtask

    task automatic test_skew();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(word4(12'(12'h200 + i), 12'(12'h310 + i), 12'(12'h320 + i), 12'(12'h330 + i)));
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = '0;
            in_data  = '0;
            if (cyc < 3) begin
                in_valid[0] = 1'b1;
                in_data[11:0] = 12'(12'h200 + cyc);
            end
            if (cyc >= 5) begin
                in_valid[3:1] = 3'b111;
                in_data[47:12] = {12'(12'h330 + cyc - 5), 12'(12'h320 + cyc - 5), 12'(12'h310 + cyc - 5)};
            end
            tick();
            if (cyc == 2) begin
                checks++;
                if (level !== LW'(3)) begin errors++; $display("FAIL skew_level: got %0d, required 3", level); end
            end
            if (cyc == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL skew_early: got %0b, required 0", out_valid); end
            end
            if (cyc == 6) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL skew_first: got %0b, required 1", out_valid); end
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL skew_third: got %0b, required 1", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL skew_end: got %0b, required 0", out_valid); end
        wait_drain(10, "skew");
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL skew_ovf: got %b, required 0000", ovf); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 4'b0100;
            in_data  = din4(12'h0, 12'h0, 12'(12'h400 + i), 12'h0);
            tick();
            if (i == 7) begin
                checks++;
                if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_full_level: got %0d, required %0d", level, DEPTH); end
            end
            if (i == 8) begin
                checks++;
                if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b, required 0100", ovf); end
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_pop: got %0b, required 0", out_valid); end
        in_data = din4(12'h0, 12'h0, 12'h4EE, 12'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr_priority: got %b, required 0000", ovf); end
        tick();
        in_valid = '0;
        checks++;
        if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_reset: got %b, required 0100", ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b, required 0000", ovf); end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(word4(12'(12'h500 + i), 12'(12'h510 + i), 12'(12'h400 + i), 12'(12'h530 + i)));
            in_valid = 4'b1011;
            in_data  = din4(12'(12'h500 + i), 12'(12'h510 + i), 12'h0, 12'(12'h530 + i));
            tick();
        end
        in_valid = '0;
        checks += 2;
        if (level !== LW'(7)) begin errors++; $display("FAIL ovf_level: got %0d, required 7", level); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b, required 1", out_valid); end
        out_ready = 1'b1;
        wait_drain(30, "overflow");
        checks += 2;
        if (ovf !== '0) begin errors++; $display("FAIL ovf_after: got %b, required 0000", ovf); end
        if (level !== '0) begin errors++; $display("FAIL ovf_level_end: got %0d, required 0", level); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40 && !(i >= 10 && exp_q.size() == 0); i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            if (i < 10) begin
                in_valid = 4'hF;
                in_data  = din4(12'(12'h600 + i), 12'(12'h610 + i), 12'(12'h620 + i), 12'(12'h630 + i));
                exp_q.push_back(word4(12'(12'h600 + i), 12'(12'h610 + i), 12'(12'h620 + i), 12'(12'h630 + i)));
            end else begin
                in_valid = '0;
            end
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        wait_drain(20, "backpressure");
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL bp_ovf: got %b, required 0000", ovf); end
    endtask

    task automatic test_mask_change();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'hF;
            in_data  = din4(12'(12'h6A0 + i), 12'(12'h6B0 + i), 12'(12'h6C0 + i), 12'(12'h6D0 + i));
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mask_pre_valid: got %0b, required 1", out_valid); end
        ch_en   = 4'h5;
        in_data = din4(12'h7EE, 12'h7EE, 12'h7EE, 12'h7EE);
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_flush_valid: got %0b, required 0", out_valid); end
        if (level !== '0) begin errors++; $display("FAIL mask_flush_level: got %0d, required 0", level); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'hF;
            in_data  = din4(12'(12'h700 + i), 12'h7A0, 12'(12'h720 + i), 12'h7B0);
            exp_q.push_back(word4(12'(12'h700 + i), 12'h0, 12'(12'h720 + i), 12'h0));
            tick();
        end
        checks++;
        if (level !== LW'(2)) begin errors++; $display("FAIL mask_level: got %0d, required 2", level); end
        for (int i = 0; i < 9; i++) begin
            in_valid = 4'b1010;
            in_data  = din4(12'h0, 12'(12'h7C0 + i), 12'h0, 12'(12'h7D0 + i));
            tick();
        end
        in_valid = '0;
        checks += 2;
        if (ovf !== '0) begin errors++; $display("FAIL mask_ovf: got %b, required 0000", ovf); end
        if (level !== LW'(2)) begin errors++; $display("FAIL mask_level_disabled: got %0d, required 2", level); end
        out_ready = 1'b1;
        wait_drain(20, "mask");
    endtask

    task automatic test_reset_mid();
        ch_en = 4'hF;
        repeat (2) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'hF;
            in_data  = din4(12'(12'h900 + i), 12'(12'h910 + i), 12'(12'h920 + i), 12'(12'h930 + i));
            tick();
        end
        in_valid = '0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %0b, required 1", out_valid); end
        if (level !== LW'(4)) begin errors++; $display("FAIL rmid_pre_level: got %0d, required 4", level); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b, required 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rmid_data: got %h, required 0", out_data); end
        if (level !== '0) begin errors++; $display("FAIL rmid_level: got %0d, required 0", level); end
`ifdef ADC_PACKER_TIMESTAMP_EN
        checks++;
        if (ts !== 32'd0) begin errors++; $display("FAIL rmid_ts: got %0d, required 0", ts); end
`endif
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %0b, required 0", out_valid); end
        end
        exp_q.push_back(word4(12'h800, 12'h801, 12'h802, 12'h803));
        in_valid = 4'hF;
        in_data  = din4(12'h800, 12'h801, 12'h802, 12'h803);
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid: got %0b, required 1", out_valid); end
`ifdef ADC_PACKER_TIMESTAMP_EN
        checks++;
        if (ts !== 32'd5) begin errors++; $display("FAIL rmid_ts_new: got %0d, required 5", ts); end
`endif
        wait_drain(10, "reset_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_overflow();
        test_back_to_back();
        test_mask_change();
        test_reset_mid();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
